// File: rtl/knn_pkg.sv
// Shared definitions for the kNN stream feeder.
// FSM encoding, result constants and point-field helpers.
`ifndef KNN_PKG_SV
`define KNN_PKG_SV
`define KNN_PT_X(p, w) p[(w)-1:(w)/2]
`define KNN_PT_Y(p, w) p[(w)/2-1:0]
`endif

package knn_pkg;

  localparam int INFO_W = 8;
  localparam logic [INFO_W-1:0] ERR_INFO = 8'hFF;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLR      = 3'd1;
  localparam logic [2:0] STREAM   = 3'd2;
  localparam logic [2:0] WAIT_RES = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  // Index width for a bank of n entries, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_point_bank.sv
// Point register file: one guarded write port, one async read.
// Cleared by reset; writes past DEPTH are dropped.
module knn_point_bank
  import knn_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int RAW  = cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [7:0]     wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic [RAW-1:0] rd_addr,
  output logic [W-1:0]   rd_data
);

  logic [W-1:0] mem [DEPTH];
  logic         in_range;

  assign in_range = 32'(wr_addr) < DEPTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en && in_range) begin
      mem[wr_addr[RAW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/knn_feeder.sv
// Drives (test, data) pairs into the kNN core and
// collects one knn_info result per test point.
module knn_feeder
  import knn_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NBR_TESTP = 4,
  parameter int NBR_DATAP = 10,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_clr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  input  logic              res_valid,
  input  logic [7:0]        res_info
);

  localparam int TW = cnt_w(NBR_TESTP);
  localparam int DW = cnt_w(NBR_DATAP);
  localparam int CW = cnt_w(TIMEOUT);

  localparam logic [TW-1:0] T_LAST = TW'(NBR_TESTP - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NBR_DATAP - 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [TW-1:0]     t;
  logic [DW-1:0]     d;
  logic [CW-1:0]     timer;
  logic              abort_clr;
  logic [INFO_W-1:0] res_mem [NBR_TESTP];

  logic bank_we;
  logic xfer;
  logic res_ok;
  logic expire;
  logic advance;
  logic kill;

  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign out_valid = state == STREAM;
  assign out_last  = out_valid && (d == D_LAST);
  assign core_clr  = (state == CLR) || abort_clr;

  assign bank_we = wr_en && !busy;
  assign kill    = abort && busy;
  assign xfer    = out_valid && out_ready;
  assign res_ok  = (state == WAIT_RES) && res_valid;
  assign expire  = (state == WAIT_RES) && !res_valid
                   && (timer == C_LAST);
  assign advance = res_ok || expire;

  knn_point_bank #(
    .W     (DATA_W),
    .DEPTH (NBR_TESTP)
  ) u_test_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we && wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (t),
    .rd_data (A)
  );

  knn_point_bank #(
    .W     (DATA_W),
    .DEPTH (NBR_DATAP)
  ) u_data_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we && !wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (d),
    .rd_data (B)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      d         <= '0;
      timer     <= '0;
      err       <= 1'b0;
      abort_clr <= 1'b0;
    end else begin
      abort_clr <= 1'b0;
      if (kill) begin
        // Leave the core with an empty list after a cancelled run.
        state     <= IDLE;
        t         <= '0;
        d         <= '0;
        timer     <= '0;
        abort_clr <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= CLR;
              err   <= 1'b0;
              t     <= '0;
              d     <= '0;
            end
          end
          CLR: begin
            state <= STREAM;
          end
          STREAM: begin
            if (xfer) begin
              if (d == D_LAST) begin
                d     <= '0;
                timer <= '0;
                state <= WAIT_RES;
              end else begin
                d <= d + 1'b1;
              end
            end
          end
          WAIT_RES: begin
            if (advance) begin
              timer <= '0;
              if (expire)
                err <= 1'b1;
              if (t == T_LAST) begin
                state <= DONE;
              end else begin
                t     <= t + 1'b1;
                state <= CLR;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            t     <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // A real result beats a timeout landing on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBR_TESTP; i++)
        res_mem[i] <= '0;
    end else if (!kill && advance) begin
      res_mem[t] <= res_ok ? res_info : ERR_INFO;
    end
  end

  assign rd_data = (32'(rd_addr) < NBR_TESTP)
                   ? res_mem[rd_addr[TW-1:0]] : '0;

endmodule
